// File: rtl/type_matcher_if.sv
// Lookup, rule-configuration and result bundle between the parse loop and type_matcher.
// The master side (header buffer / config agent) drives lookups and rule writes; the slave is the matcher.
interface type_matcher_if #(
  parameter int RULES = 16
);
  localparam int AW = (RULES > 1) ? $clog2(RULES) : 1;

  logic [44:0]   type_in;
  logic          type_in_valid;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [88:0]   cfg_data;
  logic [19:0]   addr_out;
  logic          addr_out_valid;
  logic          done_valid;
  logic [4:0]    done_ramID;
  logic [7:0]    done_state;
  logic [1:0]    done_code;

  modport master (
    output type_in, type_in_valid, cfg_wr, cfg_addr, cfg_data,
    input  addr_out, addr_out_valid, done_valid, done_ramID, done_state, done_code
  );

  modport slave (
    input  type_in, type_in_valid, cfg_wr, cfg_addr, cfg_data,
    output addr_out, addr_out_valid, done_valid, done_ramID, done_state, done_code
  );
endinterface

// File: rtl/type_matcher.sv
// Three-stage value/mask rule matcher issuing the next header extraction or a completion record.
// Optional macro TYPE_MATCHER_HOPLIMIT_EN adds per-ramID hop counters and the hop-limit abort.
module type_matcher #(
  parameter int RULES    = 16,
  parameter int MAX_HOPS = 8
) (
  input logic          clk,
  input logic          reset,
  type_matcher_if.slave bus
);
  localparam int AW = (RULES > 1) ? $clog2(RULES) : 1;

  typedef enum logic [1:0] {
    CODE_TERMINAL = 2'b00,
    CODE_MISS     = 2'b01,
    CODE_HOPLIMIT = 2'b10
  } done_code_e;

  if (RULES < 1 || RULES > 16 || MAX_HOPS < 1 || MAX_HOPS > 15) begin : g_param_check
    $error("type_matcher: RULES must be 1..16 and MAX_HOPS 1..15");
  end

  // ---------------------------------------------------------------- rule table
  logic [RULES-1:0] rule_vld_q;
  logic [7:0]       rule_state_q [RULES];
  logic [31:0]      rule_value_q [RULES];
  logic [31:0]      rule_mask_q  [RULES];
  logic [15:0]      rule_act_q   [RULES];  // {next_state, next_offset, last}

  // NOTE: only the valid bits need a reset; the bulk rule fields are plain storage
  // that is never observed while the entry is invalid, so they stay reset-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rule_vld_q <= '0;
    end else if (bus.cfg_wr) begin
      rule_vld_q[bus.cfg_addr] <= bus.cfg_data[88];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.cfg_wr) begin
      rule_state_q[bus.cfg_addr] <= bus.cfg_data[87:80];
      rule_value_q[bus.cfg_addr] <= bus.cfg_data[79:48];
      rule_mask_q[bus.cfg_addr]  <= bus.cfg_data[47:16];
      rule_act_q[bus.cfg_addr]   <= bus.cfg_data[15:0];
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [RULES-1:0] match_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < RULES; i++) begin
      match_d[i] = rule_vld_q[i]
                && (rule_state_q[i] == bus.type_in[7:0])
                && (((bus.type_in[39:8] ^ rule_value_q[i]) & rule_mask_q[i]) == 32'h0);
    end
  end

  logic             s1_vld_q;
  logic [RULES-1:0] s1_match_q;
  logic [4:0]       s1_ramid_q;
  logic [7:0]       s1_state_q;
  // Action fields are read one cycle after matching; a write landing in the match
  // cycle keeps the overwritten action here so that lookup still sees the old rule.
  logic             wr_q;
  logic [AW-1:0]    wr_addr_q;
  logic [15:0]      wr_old_act_q;

  // NOTE: sequential state always uses non-blocking '<=' so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      s1_vld_q <= bus.type_in_valid;
      wr_q     <= bus.cfg_wr;
    end
  end

  always_ff @(posedge clk) begin
    s1_match_q <= match_d;
    s1_ramid_q <= bus.type_in[44:40];
    s1_state_q <= bus.type_in[7:0];
    wr_addr_q  <= bus.cfg_addr;
    if (bus.cfg_wr) wr_old_act_q <= rule_act_q[bus.cfg_addr];
  end

  // ---------------------------------------------------------------- stage 2
  logic [AW-1:0] sel_idx;
  logic          sel_hit;
  logic [15:0]   sel_act;

  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = RULES - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        sel_idx = AW'(i);
        sel_hit = 1'b1;
      end
    end
    sel_act = (wr_q && (wr_addr_q == sel_idx)) ? wr_old_act_q : rule_act_q[sel_idx];
  end

  logic       s2_vld_q;
  logic       s2_hit_q;
  logic [4:0] s2_ramid_q;
  logic [7:0] s2_state_q;
  logic [7:0] s2_next_q;
  logic [6:0] s2_off_q;
  logic       s2_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s2_vld_q <= 1'b0;
    else        s2_vld_q <= s1_vld_q;
  end

  always_ff @(posedge clk) begin
    s2_hit_q   <= sel_hit;
    s2_ramid_q <= s1_ramid_q;
    s2_state_q <= s1_state_q;
    s2_next_q  <= sel_act[15:8];
    s2_off_q   <= sel_act[7:1];
    s2_last_q  <= sel_act[0];
  end

  // ---------------------------------------------------------------- stage 3
`ifdef TYPE_MATCHER_HOPLIMIT_EN
  localparam logic [3:0] MAX_HOPS_C = 4'(MAX_HOPS);
  logic [3:0] hops_q [32];
  logic [3:0] hop_cnt;

  assign hop_cnt = hops_q[s2_ramid_q];
`endif

  logic       emit_addr_d;
  logic       emit_done_d;
  done_code_e code_d;
  logic [7:0] final_state_d;

  always_comb begin
    emit_addr_d   = 1'b0;
    emit_done_d   = 1'b0;
    code_d        = CODE_TERMINAL;
    final_state_d = s2_state_q;
    if (s2_vld_q) begin
      if (!s2_hit_q) begin
        emit_done_d = 1'b1;
        code_d      = CODE_MISS;
      end else if (s2_last_q) begin
        emit_done_d   = 1'b1;
        final_state_d = s2_next_q;
      end else begin
`ifdef TYPE_MATCHER_HOPLIMIT_EN
        if (hop_cnt == MAX_HOPS_C) begin
          emit_done_d = 1'b1;
          code_d      = CODE_HOPLIMIT;
        end else
`endif
        emit_addr_d = 1'b1;
      end
    end
  end

`ifdef TYPE_MATCHER_HOPLIMIT_EN
  // Every completion ends the packet's parse, so any done clears its counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) hops_q[i] <= 4'd0;
    end else if (emit_addr_d) begin
      hops_q[s2_ramid_q] <= hop_cnt + 4'd1;
    end else if (emit_done_d) begin
      hops_q[s2_ramid_q] <= 4'd0;
    end
  end
`endif

  logic [19:0] addr_out_q;
  logic        addr_out_valid_q;
  logic        done_valid_q;
  logic [4:0]  done_ramid_q;
  logic [7:0]  done_state_q;
  logic [1:0]  done_code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_out_q       <= '0;
      addr_out_valid_q <= 1'b0;
      done_valid_q     <= 1'b0;
      done_ramid_q     <= '0;
      done_state_q     <= '0;
      done_code_q      <= '0;
    end else begin
      addr_out_valid_q <= emit_addr_d;
      done_valid_q     <= emit_done_d;
      if (emit_addr_d) addr_out_q <= {s2_next_q, s2_ramid_q, s2_off_q};
      if (emit_done_d) begin
        done_ramid_q <= s2_ramid_q;
        done_state_q <= final_state_d;
        done_code_q  <= code_d;
      end
    end
  end

  assign bus.addr_out       = addr_out_q;
  assign bus.addr_out_valid = addr_out_valid_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_ramID     = done_ramid_q;
  assign bus.done_state     = done_state_q;
  assign bus.done_code      = done_code_q;
endmodule

// File: tb/tb_type_matcher.sv
// Directed self-checking bench for type_matcher: hits, priority, terminal/miss, hop limit,
// config/lookup race and mid-flight reset. Hop-limit expectations follow TYPE_MATCHER_HOPLIMIT_EN.
module tb_type_matcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  type_matcher_if #(.RULES(16)) bus ();

  type_matcher #(.RULES(16), .MAX_HOPS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [88:0] rule(input logic vld, input logic [7:0] st, input logic [31:0] value,
                                       input logic [31:0] mask, input logic [7:0] nxt,
                                       input logic [6:0] off, input logic last);
    return {vld, st, value, mask, nxt, off, last};
  endfunction

  task automatic write_rule(input logic [3:0] idx, input logic [88:0] data);
    @(negedge clk);
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = idx;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_wr   = 1'b0;
  endtask

  // Drives one lookup, verifies nothing appears at T+2, then checks the result at T+3.
  task automatic lookup(input string tag, input logic [4:0] id, input logic [31:0] win,
                        input logic [7:0] st, input logic exp_addr, input logic [19:0] exp_addr_out,
                        input logic [1:0] exp_code, input logic [7:0] exp_state);
    @(negedge clk);
    bus.type_in       = {id, win, st};
    bus.type_in_valid = 1'b1;
    @(negedge clk);
    bus.type_in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".early"}, {31'd0, bus.addr_out_valid | bus.done_valid}, 32'd0);
    @(negedge clk);
    check({tag, ".addr_vld"}, {31'd0, bus.addr_out_valid}, {31'd0, exp_addr});
    check({tag, ".done_vld"}, {31'd0, bus.done_valid}, {31'd0, ~exp_addr});
    if (exp_addr) begin
      check({tag, ".addr"}, {12'd0, bus.addr_out}, {12'd0, exp_addr_out});
    end else begin
      check({tag, ".rid"},   {27'd0, bus.done_ramID}, {27'd0, id});
      check({tag, ".code"},  {30'd0, bus.done_code},  {30'd0, exp_code});
      check({tag, ".state"}, {24'd0, bus.done_state}, {24'd0, exp_state});
      check({tag, ".hold"},  {12'd0, bus.addr_out},   {12'd0, exp_addr_out});
    end
  endtask

  initial begin
    logic [19:0] loop_addr;
    int          n_addr;
    int          n_done;
    bit          hop_en;
`ifdef TYPE_MATCHER_HOPLIMIT_EN
    hop_en = 1'b1;
`else
    hop_en = 1'b0;
`endif
    bus.type_in       = '0;
    bus.type_in_valid = 1'b0;
    bus.cfg_wr        = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_data      = '0;
    repeat (3) @(negedge clk);
    check("rst.addr",      {12'd0, bus.addr_out}, 32'd0);
    check("rst.strobes",   {30'd0, bus.addr_out_valid, bus.done_valid}, 32'd0);
    check("rst.done_data", {17'd0, bus.done_ramID, bus.done_state, bus.done_code}, 32'd0);
    reset = 1'b1;

    // Basic hit: {02, 3, 14} = 0x0218E
    write_rule(4'd0, rule(1'b1, 8'h01, 32'h0800_0000, 32'hFFFF_0000, 8'h02, 7'd14, 1'b0));
    lookup("basic", 5'd3, 32'h0800_4500, 8'h01, 1'b1, 20'h0218E, 2'b00, 8'h00);

    // Priority: both entries wildcard on type for state 0x20; lowest index wins
    write_rule(4'd2, rule(1'b1, 8'h20, 32'hDEAD_BEEF, 32'h0, 8'h04, 7'd10, 1'b0));
    write_rule(4'd5, rule(1'b1, 8'h20, 32'h0,         32'h0, 8'h07, 7'd20, 1'b0));
    lookup("prio2", 5'd4, 32'h1234_5678, 8'h20, 1'b1, {8'h04, 5'd4, 7'd10}, 2'b00, 8'h00);
    write_rule(4'd2, rule(1'b0, 8'h20, 32'h0, 32'h0, 8'h04, 7'd10, 1'b0));
    lookup("prio5", 5'd4, 32'h1234_5678, 8'h20, 1'b1, {8'h07, 5'd4, 7'd20}, 2'b00, 8'h00);

    // Terminal hit, masked-type miss, unknown-state miss; addr_out must hold {07,4,20}
    write_rule(4'd3, rule(1'b1, 8'h10, 32'h0000_0006, 32'h0000_00FF, 8'hFF, 7'd0, 1'b1));
    lookup("term",  5'd9,  32'h1234_5606, 8'h10, 1'b0, {8'h07, 5'd4, 7'd20}, 2'b00, 8'hFF);
    lookup("mmiss", 5'd10, 32'h1234_5611, 8'h10, 1'b0, {8'h07, 5'd4, 7'd20}, 2'b01, 8'h10);
    lookup("miss",  5'd21, 32'hCAFE_F00D, 8'h33, 1'b0, {8'h07, 5'd4, 7'd20}, 2'b01, 8'h33);

    // Hop limit: 9 back-to-back lookups on ramID 7 through a self-looping rule
    write_rule(4'd6, rule(1'b1, 8'h05, 32'h0, 32'h0, 8'h05, 7'h20, 1'b0));
    loop_addr = {8'h05, 5'd7, 7'h20};
    n_addr = 0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        if (bus.addr_out_valid) n_addr++;
        if (bus.done_valid)     n_done++;
        if (hop_en && k == 11) begin
          check("hop.limit_done", {31'd0, bus.done_valid}, 32'd1);
          check("hop.limit_code", {30'd0, bus.done_code}, 32'd2);
          check("hop.limit_state", {24'd0, bus.done_state}, 32'h05);
          check("hop.limit_rid", {27'd0, bus.done_ramID}, 32'd7);
        end else begin
          check("hop.step_addr", {12'd0, bus.addr_out_valid, bus.addr_out},
                {12'd0, 1'b1, loop_addr});
        end
      end
      bus.type_in       = {5'd7, 32'h0, 8'h05};
      bus.type_in_valid = (k < 9);
    end
    check("hop.n_addr", n_addr, hop_en ? 32'd8 : 32'd9);
    check("hop.n_done", n_done, hop_en ? 32'd1 : 32'd0);
    lookup("hop.after", 5'd7, 32'h0, 8'h05, 1'b1, loop_addr, 2'b00, 8'h00);

    // Config/lookup race: entry 0 written in the lookup cycle is not seen; next cycle hits
    write_rule(4'd0, rule(1'b0, 8'h01, 32'h0800_0000, 32'hFFFF_0000, 8'h02, 7'd14, 1'b0));
    @(negedge clk);
    bus.cfg_wr        = 1'b1;
    bus.cfg_addr      = 4'd0;
    bus.cfg_data      = rule(1'b1, 8'h01, 32'h0800_0000, 32'hFFFF_0000, 8'h02, 7'd14, 1'b0);
    bus.type_in       = {5'd3, 32'h0800_4500, 8'h01};
    bus.type_in_valid = 1'b1;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    @(negedge clk);
    bus.type_in_valid = 1'b0;
    @(negedge clk);
    check("race.miss_vld",  {30'd0, bus.done_valid, bus.addr_out_valid}, 32'd2);
    check("race.miss_code", {30'd0, bus.done_code}, 32'd1);
    @(negedge clk);
    check("race.hit", {11'd0, bus.addr_out_valid, bus.addr_out}, {11'd0, 1'b1, 20'h0218E});

    // Rewriting a matched entry's action in the lookup cycle keeps the old action for it
    @(negedge clk);
    bus.cfg_wr        = 1'b1;
    bus.cfg_data      = rule(1'b1, 8'h01, 32'h0800_0000, 32'hFFFF_0000, 8'h0A, 7'd14, 1'b0);
    bus.type_in_valid = 1'b1;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    @(negedge clk);
    bus.type_in_valid = 1'b0;
    @(negedge clk);
    check("race.old_act", {11'd0, bus.addr_out_valid, bus.addr_out}, {11'd0, 1'b1, 20'h0218E});
    @(negedge clk);
    check("race.new_act", {11'd0, bus.addr_out_valid, bus.addr_out}, {11'd0, 1'b1, 20'h0A18E});

    // Reset at T+1 of a lookup: no strobe, outputs cleared, rules gone afterwards
    @(negedge clk);
    bus.type_in_valid = 1'b1;
    @(negedge clk);
    bus.type_in_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rreset.t2", {30'd0, bus.addr_out_valid, bus.done_valid}, 32'd0);
    @(negedge clk);
    check("rreset.t3", {30'd0, bus.addr_out_valid, bus.done_valid}, 32'd0);
    check("rreset.outs", {12'd0, bus.addr_out} | {17'd0, bus.done_ramID, bus.done_state, bus.done_code},
          32'd0);
    reset = 1'b1;
    lookup("rreset.cleared", 5'd3, 32'h0800_4500, 8'h01, 1'b0, 20'h0, 2'b01, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/type_matcher.md
# type_matcher

Downstream neighbour of the header buffer in the parse loop. It consumes the 45-bit `{ramID, 32-bit type window, 8-bit state}` words the header buffer extracts and matches them against a programmable value/mask rule table keyed by parser state. On a match it issues the next 20-bit extraction request `{next_state, ramID, byte_offset}` back to the header buffer. It terminates the packet's parse with a completion record when a terminal rule hits, no rule hits, or the hop limit is reached.

## Interface
- `RULES`, 16, number of rule entries (power of two, max 16); `cfg_addr` width is log2(RULES).
- `MAX_HOPS`, 8, maximum extraction requests issued per ramID before abort (1..15).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `type_in`  in  45  [44:40] ramID, [39:8] type window, [7:0] current state.
- `type_in_valid`  in  1  one-cycle strobe per lookup.
- `cfg_wr`  in  1  rule write strobe.
- `cfg_addr`  in  4  rule index.
- `cfg_data`  in  89  [88] entry valid, [87:80] match state, [79:48] value, [47:16] mask, [15:8] next state, [7:1] next byte offset, [0] last.
- `addr_out`  out  20  [19:12] next state, [11:7] ramID, [6:0] byte offset; header-buffer request format.
- `addr_out_valid`  out  1  one-cycle strobe.
- `done_valid`  out  1  one-cycle completion strobe.
- `done_ramID`  out  5  packet slot finished.
- `done_state`  out  8  final state: next state of the terminal rule, otherwise the input state.
- `done_code`  out  2  00 terminal rule hit, 01 miss, 10 hop limit, 11 unused.

## Operation
- Rule table: RULES x 89-bit registers. All entries are invalid at reset. Written only through `cfg_wr`; no readback.
- Entry i matches when valid, match state equals `type_in[7:0]`, and `((type ^ value) & mask) == 0`. A mask of 0 is a wildcard on type.
- Lowest matching index wins.
- Stage 1: register the match vector, ramID, state and valid.
- Stage 2: priority-encode the match vector and register the selected entry fields plus hit flag.
- Stage 3: form outputs, then run the hop counter read-modify-write.
  - Hit, last=0: emit `addr_out = {next_state, ramID, next_offset}`. Increment `hops[ramID]`.
  - Hit, last=1: emit done with code 00 and `done_state = next_state`. Clear `hops[ramID]`.
  - Miss: emit done with code 01 and `done_state = input state`. Clear `hops[ramID]`.
  - Hop limit: hit with last=0 while `hops[ramID] == MAX_HOPS` emits done with code 10 instead of `addr_out`, and clears the counter.
- `addr_out_valid` and `done_valid` are mutually exclusive. Exactly one of them fires per accepted lookup.
- Byte offset is absolute within the 128-byte header slot. No arithmetic is applied; the rule supplies it verbatim.

## Timing
- Latency is 3 cycles: `type_in_valid` at cycle T gives `addr_out_valid` or `done_valid` at T+3.
- Throughput is 1 lookup per cycle. There is no backpressure; consumers always accept.
- All outputs are registered. Reset values: `addr_out` 0, `addr_out_valid` 0, `done_valid` 0, `done_ramID` 0, `done_state` 0, `done_code` 0. Data outputs hold their last value when the strobe is low.
- `cfg_wr` at cycle C affects lookups whose `type_in_valid` is at cycle C+1 or later. A write coinciding with a lookup does not affect that lookup.
- Hop counters are 4 bits x 32, read and written within stage 3, so back-to-back lookups on the same ramID see updated counts with no hazard.
- Simultaneous increment and clear cannot occur, since only one stage-3 op runs per cycle.
- Asserting reset mid-operation:
  - drops in-flight lookups with no outputs;
  - clears all rules and counters.

## Configuration
- `TYPE_MATCHER_HOPLIMIT_EN` defined: hop counters and code 10 are present as described.
- `TYPE_MATCHER_HOPLIMIT_EN` undefined:
  - no counter storage;
  - every non-last hit emits `addr_out`;
  - code 10 is never produced;
  - `MAX_HOPS` is ignored.

## Test plan
- Basic hit: entry 0 = {valid, state 0x01, value 0x08000000, mask 0xFFFF0000, next 0x02, offset 14, last 0}. Lookup `type_in = {5'd3, 32'h0800_4500, 8'h01}` -> at T+3 `addr_out = 20'h0218E`, `addr_out_valid = 1`.
- Priority: entries 2 and 5 both match, entry 5 has next state 0x07, entry 2 has 0x04 -> `addr_out[19:12] = 0x04`. Invalidate entry 2 -> 0x07.
- Terminal and miss:
  - Last=1 hit with next 0xFF -> `done_valid`, code 00, `done_state` 0xFF.
  - State 0x33 with no rule -> code 01, `done_state` 0x33, ramID echoed.
- Hop limit: a self-looping rule (state 0x05 -> 0x05, last 0) fed 9 lookups for ramID 7 -> 8 `addr_out` strobes, then done code 10. A following lookup on ramID 7 yields `addr_out` again. Rerun with the macro undefined -> 9 `addr_out`.
- Config/reset race:
  - Write entry 0 in the same cycle as a matching lookup -> miss.
  - The next-cycle lookup hits.
  - Reset asserted at T+1 of a lookup -> no strobes, all outputs 0.
